// File: rtl/perceptron_pkg.sv
// perceptron_pkg
//   Shared types, half-precision constants and small half-float helpers for the
//   perceptron trainer, its evaluator and the multi16/sum16 arithmetic cells.
//   Helpers model a half value as m * 2^(e-25), where m is the 11-bit significand
//   (hidden bit included) and e the effective exponent (subnormals use e=1).
package perceptron_pkg;

    localparam int          SIGN_BIT = 15;
    localparam logic [15:0] HF_ZERO  = 16'h0000;
    localparam logic [15:0] HF_ETA   = 16'h3800;   // +0.5
    localparam logic [15:0] HF_BIAS  = 16'hBA66;   // about -0.8
    localparam int          EPOCH_W  = 4;

    typedef logic [EPOCH_W-1:0] epoch_t;

    typedef enum logic [2:0] {IDLE, EVAL, UPD, CHECK, DONE} state_t;

    function automatic logic [10:0] hf_mant(input logic [15:0] h);
        return {(h[14:10] != 5'd0), h[9:0]};
    endfunction

    function automatic int hf_exp(input logic [15:0] h);
        return (h[14:10] == 5'd0) ? 1 : int'(h[14:10]);
    endfunction

    function automatic logic hf_is_nan(input logic [15:0] h);
        return (h[14:10] == 5'h1f) && (h[9:0] != 10'd0);
    endfunction

    function automatic logic hf_is_inf(input logic [15:0] h);
        return (h[14:10] == 5'h1f) && (h[9:0] == 10'd0);
    endfunction

    // Packs the exact value mag * 2^scale into half precision, truncating toward
    // zero. Overflow gives infinity; tiny values become subnormal or zero.
    function automatic logic [15:0] hf_pack(input logic sgn, input logic [41:0] mag,
                                            input int scale);
        int         lead;
        int         e;
        int         sh;
        logic [10:0] m;
        lead = -1;
        for (int i = 0; i < 42; i++) begin
            if (mag[i]) lead = i;
        end
        if (lead < 0) return {sgn, 15'h0000};
        e = lead + scale + 15;
        if (e > 30) return {sgn, 5'h1f, 10'h000};
        if (e < 1) e = 1;
        sh = e - 25 - scale;
        m  = (sh >= 0) ? 11'(mag >> sh) : 11'(mag << (-sh));
        return {sgn, (m[10] ? e[4:0] : 5'd0), m[9:0]};
    endfunction

endpackage

// File: rtl/perceptron_if.sv
// perceptron_if
//   Bundles the trainer's control, sample and weight signals.
//   master: drives start, samples (in1, in2, d) and initial weights; observes status.
//   slave : the trainer; drives w0..w2, busy, done, converged, epoch.
interface perceptron_if
    import perceptron_pkg::*;
#(
    parameter int tam = 16
) ();
    logic                start;
    logic [3:0][tam-1:0] in1;
    logic [3:0][tam-1:0] in2;
    logic [3:0]          d;
    logic [tam-1:0]      w0_init;
    logic [tam-1:0]      w1_init;
    logic [tam-1:0]      w2_init;
    logic [tam-1:0]      w0;
    logic [tam-1:0]      w1;
    logic [tam-1:0]      w2;
    logic                busy;
    logic                done;
    logic                converged;
    epoch_t              epoch;

    modport master (
        output start, in1, in2, d, w0_init, w1_init, w2_init,
        input  w0, w1, w2, busy, done, converged, epoch
    );

    modport slave (
        input  start, in1, in2, d, w0_init, w1_init, w2_init,
        output w0, w1, w2, busy, done, converged, epoch
    );
endinterface

// File: rtl/hf_cells.sv
// multi16 / sum16
//   Combinational half-precision multiplier and adder with round-toward-zero.
//   Ports: en (output forced to +0 when low), a, b (operands), y (result).
//   Both form the exact result as a wide integer, then truncate once in hf_pack.
module multi16
    import perceptron_pkg::*;
(
    input  logic        en,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic        sgn;
    logic [41:0] ma;
    logic [41:0] mb;
    logic [15:0] res;

    always_comb begin
        sgn = a[SIGN_BIT] ^ b[SIGN_BIT];
        ma  = 42'(hf_mant(a));
        mb  = 42'(hf_mant(b));
        if (hf_is_nan(a) || hf_is_nan(b)) begin
            res = {sgn, 5'h1f, 10'h200};
        end else if (hf_is_inf(a) || hf_is_inf(b)) begin
            res = {sgn, 5'h1f, 10'h000};
        end else begin
            res = hf_pack(sgn, ma * mb, hf_exp(a) + hf_exp(b) - 50);
        end
        y = en ? res : HF_ZERO;
    end
endmodule

module sum16
    import perceptron_pkg::*;
(
    input  logic        en,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    int          ea;
    int          eb;
    int          emn;
    logic [41:0] ma;
    logic [41:0] mb;
    logic [41:0] mag;
    logic        sgn;
    logic [15:0] res;

    always_comb begin
        ea  = hf_exp(a);
        eb  = hf_exp(b);
        emn = (ea < eb) ? ea : eb;
        // Align both significands on the finer exponent: exact, no bits dropped.
        ma  = 42'(hf_mant(a)) << (ea - emn);
        mb  = 42'(hf_mant(b)) << (eb - emn);
        if (a[SIGN_BIT] == b[SIGN_BIT]) begin
            mag = ma + mb;
            sgn = a[SIGN_BIT];
        end else if (ma >= mb) begin
            mag = ma - mb;
            sgn = a[SIGN_BIT];
        end else begin
            mag = mb - ma;
            sgn = b[SIGN_BIT];
        end
        // An exact zero is -0 only when both operands were negative.
        if (mag == 42'd0) sgn = a[SIGN_BIT] & b[SIGN_BIT];
        if (hf_is_nan(a) || hf_is_nan(b) ||
            (hf_is_inf(a) && hf_is_inf(b) && (a[SIGN_BIT] != b[SIGN_BIT]))) begin
            res = 16'h7e00;
        end else if (hf_is_inf(a)) begin
            res = a;
        end else if (hf_is_inf(b)) begin
            res = b;
        end else begin
            res = hf_pack(sgn, mag, emn - 25);
        end
        y = en ? res : HF_ZERO;
    end
endmodule

// File: rtl/perceptron_eval.sv
// perceptron_eval
//   Combinational three-input perceptron: v = (x0*w0 + x1*w1) + x2*w2, y = ~sign(v).
//   Ports: x0..x2 inputs, w0..w2 weights, v dot product, y class (-0 gives 0).
module perceptron_eval
    import perceptron_pkg::*;
#(
    parameter int tam = 16
) (
    input  logic [tam-1:0] x0,
    input  logic [tam-1:0] x1,
    input  logic [tam-1:0] x2,
    input  logic [tam-1:0] w0,
    input  logic [tam-1:0] w1,
    input  logic [tam-1:0] w2,
    output logic [tam-1:0] v,
    output logic           y
);
    logic [tam-1:0] m0;
    logic [tam-1:0] m1;
    logic [tam-1:0] m2;
    logic [tam-1:0] s01;

    multi16 u_m0 (.en(1'b1), .a(x0), .b(w0), .y(m0));
    multi16 u_m1 (.en(1'b1), .a(x1), .b(w1), .y(m1));
    multi16 u_m2 (.en(1'b1), .a(x2), .b(w2), .y(m2));
    sum16   u_s0 (.en(1'b1), .a(m0), .b(m1), .y(s01));
    sum16   u_s1 (.en(1'b1), .a(s01), .b(m2), .y(v));

    assign y = ~v[SIGN_BIT];
endmodule

// File: rtl/perceptron_trainer.sv
// perceptron_trainer
//   Trains w0..w2 with the perceptron rule over a latched four-sample set until an
//   epoch has no errors or MAX_EPOCH epochs have run.
//   Ports: clk, rst (async, active high), bus (perceptron_if.slave): start, in1,
//   in2, d, w*_init in; w0..w2 (registered), busy, done, converged, epoch out.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int          tam       = 16,
    parameter int          MAX_EPOCH = 15,
    parameter logic [15:0] ETA       = HF_ETA,
    parameter logic [15:0] BIAS      = HF_BIAS
) (
    input  logic        clk,
    input  logic        rst,
    perceptron_if.slave bus
);
    state_t              state;
    state_t              state_nxt;
    logic [3:0][tam-1:0] s_in1;
    logic [3:0][tam-1:0] s_in2;
    logic [3:0]          s_d;
    logic [tam-1:0]      w0, w1, w2;
    logic [tam-1:0]      w0_nxt, w1_nxt, w2_nxt;
    logic [tam-1:0]      p0, p1, p2;
    logic [tam-1:0]      q0, q1, q2;
    logic [tam-1:0]      x1_cur, x2_cur;
    logic [tam-1:0]      eval_v;
    logic                eval_y;
    logic                unused_eval_v;
    logic [1:0]          idx;
    logic [2:0]          err_cnt;
    epoch_t              epoch;
    logic                converged;
    logic                y_q;
    logic                busy;
    logic                done;
    logic                flip;

    assign x1_cur = s_in1[idx];
    assign x2_cur = s_in2[idx];

    perceptron_eval #(.tam(tam)) u_eval (
        .x0(BIAS), .x1(x1_cur), .x2(x2_cur),
        .w0(w0), .w1(w1), .w2(w2),
        .v(eval_v), .y(eval_y)
    );
    // Only the class bit is needed here; v exists for the downstream tester.
    assign unused_eval_v = ^eval_v;

    // Update path: w_k + (+/-)ETA*x_k, negated when the desired class is 0.
    assign flip = ~s_d[idx];
    multi16 u_p0 (.en(1'b1), .a(ETA), .b(BIAS),   .y(p0));
    multi16 u_p1 (.en(1'b1), .a(ETA), .b(x1_cur), .y(p1));
    multi16 u_p2 (.en(1'b1), .a(ETA), .b(x2_cur), .y(p2));
    assign q0 = {p0[SIGN_BIT] ^ flip, p0[SIGN_BIT-1:0]};
    assign q1 = {p1[SIGN_BIT] ^ flip, p1[SIGN_BIT-1:0]};
    assign q2 = {p2[SIGN_BIT] ^ flip, p2[SIGN_BIT-1:0]};
    sum16 u_w0 (.en(1'b1), .a(w0), .b(q0), .y(w0_nxt));
    sum16 u_w1 (.en(1'b1), .a(w1), .b(q1), .y(w1_nxt));
    sum16 u_w2 (.en(1'b1), .a(w2), .b(q2), .y(w2_nxt));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nxt = EVAL;
            EVAL: begin
                busy      = 1'b1;
                state_nxt = UPD;
            end
            UPD: begin
                busy      = 1'b1;
                state_nxt = (idx == 2'd3) ? CHECK : EVAL;
            end
            CHECK: begin
                busy = 1'b1;
                if (err_cnt == 3'd0 || int'(epoch) + 1 == MAX_EPOCH) state_nxt = DONE;
                else                                                 state_nxt = EVAL;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the sample registers are pure data, written before any use on
    // start, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            s_in1 <= bus.in1;
            s_in2 <= bus.in2;
            s_d   <= bus.d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w0        <= HF_ZERO;
            w1        <= HF_ZERO;
            w2        <= HF_ZERO;
            idx       <= 2'd0;
            err_cnt   <= 3'd0;
            epoch     <= '0;
            converged <= 1'b0;
            y_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    w0        <= bus.w0_init;
                    w1        <= bus.w1_init;
                    w2        <= bus.w2_init;
                    idx       <= 2'd0;
                    err_cnt   <= 3'd0;
                    epoch     <= '0;
                    converged <= 1'b0;
                end
                EVAL: y_q <= eval_y;
                UPD: begin
                    if (y_q != s_d[idx]) begin
                        w0      <= w0_nxt;
                        w1      <= w1_nxt;
                        w2      <= w2_nxt;
                        err_cnt <= err_cnt + 3'd1;
                    end
                    idx <= idx + 2'd1;   // wraps to 0 after sample 3
                end
                CHECK: begin
                    epoch   <= epoch + 1'b1;
                    if (err_cnt == 3'd0) converged <= 1'b1;
                    idx     <= 2'd0;
                    err_cnt <= 3'd0;
                end
                default: ;
            endcase
        end
    end

    assign bus.w0        = w0;
    assign bus.w1        = w1;
    assign bus.w2        = w2;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.converged = converged;
    assign bus.epoch     = epoch;
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer
//   Scoreboard bench: each started run pushes the result of a real-valued
//   reference model (half precision, truncation toward zero) and the entry is
//   popped and compared when done pulses.
module tb_perceptron_trainer;
    import perceptron_pkg::*;

    localparam int MAX_EP       = 15;
    localparam int MODE_NORMAL  = 0;
    localparam int MODE_DISTURB = 1;
    localparam int MODE_PROBE   = 2;
    localparam int MODE_ABORT   = 3;
    localparam logic [3:0][15:0] OR_IN1 = {16'h3C00, 16'h3C00, 16'h0000, 16'h0000};
    localparam logic [3:0][15:0] OR_IN2 = {16'h3C00, 16'h0000, 16'h3C00, 16'h0000};

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [3:0]  epoch;
        logic        conv;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t last_exp;
    exp_t or_exp;

    always #5 clk = ~clk;

    perceptron_if #(.tam(16)) bus ();

    perceptron_trainer #(.tam(16), .MAX_EPOCH(MAX_EP), .ETA(HF_ETA), .BIAS(HF_BIAS)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    logic [15:0] tx1, tx2, tv;
    logic        ty;
    perceptron_eval #(.tam(16)) u_tester (
        .x0(HF_BIAS), .x1(tx1), .x2(tx2),
        .w0(bus.w0), .w1(bus.w1), .w2(bus.w2),
        .v(tv), .y(ty)
    );

    // ---------------- reference model ----------------
    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else        repeat (-n) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real mag;
        if (h[14:10] == 5'd0) mag = real'(h[9:0]) * pow2(-24);
        else                  mag = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
        return h[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] r2h(input real r, input logic zero_sign);
        real  mag;
        logic sgn;
        int   e;
        int   f;
        if (r == 0.0) return {zero_sign, 15'h0000};
        sgn = (r < 0.0);
        mag = sgn ? -r : r;
        if (mag >= 65536.0) return {sgn, 5'h1f, 10'h000};
        if (mag < pow2(-14)) begin
            f = $rtoi(mag / pow2(-24));
            return {sgn, 5'd0, f[9:0]};
        end
        e = 1;
        while (e < 30 && mag >= pow2(e - 14)) e++;
        f = $rtoi(mag / pow2(e - 25));
        return {sgn, e[4:0], f[9:0]};
    endfunction

    function automatic logic [15:0] hmul(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) * h2r(b), a[15] ^ b[15]);
    endfunction

    function automatic logic [15:0] hadd(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) + h2r(b), a[15] & b[15]);
    endfunction

    function automatic logic [15:0] model_v(input logic [15:0] x1, input logic [15:0] x2,
                                            input logic [15:0] a0, input logic [15:0] a1,
                                            input logic [15:0] a2);
        return hadd(hadd(hmul(HF_BIAS, a0), hmul(x1, a1)), hmul(x2, a2));
    endfunction

    function automatic exp_t model_run(input logic [3:0][15:0] i1, input logic [3:0][15:0] i2,
                                       input logic [3:0] dd, input logic [15:0] a0,
                                       input logic [15:0] a1, input logic [15:0] a2);
        exp_t        r;
        logic [15:0] w [3];
        logic [15:0] x [3];
        logic [15:0] v;
        logic [15:0] p;
        int          err;
        int          ep;
        w[0] = a0; w[1] = a1; w[2] = a2;
        r.conv = 1'b0;
        ep = 0;
        for (int e = 0; e < MAX_EP; e++) begin
            err = 0;
            for (int i = 0; i < 4; i++) begin
                x[0] = HF_BIAS; x[1] = i1[i]; x[2] = i2[i];
                v = model_v(x[1], x[2], w[0], w[1], w[2]);
                if (~v[15] != dd[i]) begin
                    for (int k = 0; k < 3; k++) begin
                        p = hmul(HF_ETA, x[k]);
                        if (!dd[i]) p[15] = ~p[15];
                        w[k] = hadd(w[k], p);
                    end
                    err++;
                end
            end
            ep++;
            if (err == 0) begin
                r.conv = 1'b1;
                break;
            end
        end
        r.w0 = w[0]; r.w1 = w[1]; r.w2 = w[2];
        r.epoch = 4'(ep);
        return r;
    endfunction

    // ---------------- run driver / scoreboard ----------------
    task automatic drive_run(input string name, input logic [3:0][15:0] i1,
                             input logic [3:0][15:0] i2, input logic [3:0] dd,
                             input logic [15:0] a0, input logic [15:0] a1,
                             input logic [15:0] a2, input int mode);
        exp_t e;
        bit   seen = 0;
        int   lat  = 0;
        @(negedge clk);
        bus.in1 = i1; bus.in2 = i2; bus.d = dd;
        bus.w0_init = a0; bus.w1_init = a1; bus.w2_init = a2;
        bus.start = 1'b1;
        if (mode != MODE_ABORT) sb.push_back(model_run(i1, i2, dd, a0, a1, a2));
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (mode == MODE_DISTURB && (n == 3 || n == 9)) begin
                bus.start = 1'b1;
                bus.in1 = ~i1; bus.in2 = ~i2; bus.d = ~dd;
                bus.w0_init = 16'h4000; bus.w1_init = 16'hC000; bus.w2_init = 16'h3C00;
            end
            if (mode == MODE_ABORT && n == 20) begin
                rst = 1'b1;
                #1;
                checks++;
                if ({bus.w0, bus.w1, bus.w2, bus.epoch, bus.busy, bus.done, bus.converged} !== '0) begin
                    failures++;
                    $display("FAIL %s.reset_now got w=%h/%h/%h ep=%0d busy=%b done=%b conv=%b exp all 0",
                             name, bus.w0, bus.w1, bus.w2, bus.epoch, bus.busy, bus.done, bus.converged);
                end
                @(posedge clk); #1;
                checks++;
                if ({bus.w0, bus.w1, bus.w2, bus.epoch, bus.busy, bus.done, bus.converged} !== '0) begin
                    failures++;
                    $display("FAIL %s.reset_held got w=%h/%h/%h ep=%0d busy=%b done=%b conv=%b exp all 0",
                             name, bus.w0, bus.w1, bus.w2, bus.epoch, bus.busy, bus.done, bus.converged);
                end
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (n == 1) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s.busy_after_start got=%b exp=1", name, bus.busy);
                end
            end
            if (mode == MODE_PROBE && n == 1) begin
                checks++;
                if ({bus.w0, bus.w1, bus.w2} !== {a0, a1, a2}) begin
                    failures++;
                    $display("FAIL %s.w_before_upd got=%h/%h/%h exp=%h/%h/%h",
                             name, bus.w0, bus.w1, bus.w2, a0, a1, a2);
                end
            end
            if (mode == MODE_PROBE && n == 2) begin
                checks++;
                if ({bus.w0, bus.w1, bus.w2} !== {16'h3666, 16'h0000, 16'h0000}) begin
                    failures++;
                    $display("FAIL %s.first_upd got=%h/%h/%h exp=3666/0000/0000",
                             name, bus.w0, bus.w1, bus.w2);
                end
            end
            if (bus.done === 1'b1) begin
                seen = 1;
                lat  = n;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s.timeout got=no done exp=done within 200 cycles", name);
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        last_exp = e;
        if (!seen) return;
        checks++;
        if (bus.w0 !== e.w0 || bus.w1 !== e.w1 || bus.w2 !== e.w2) begin
            failures++;
            $display("FAIL %s.weights got=%h/%h/%h exp=%h/%h/%h",
                     name, bus.w0, bus.w1, bus.w2, e.w0, e.w1, e.w2);
        end
        checks++;
        if (bus.epoch !== e.epoch || bus.converged !== e.conv) begin
            failures++;
            $display("FAIL %s.status got ep=%0d conv=%b exp ep=%0d conv=%b",
                     name, bus.epoch, bus.converged, e.epoch, e.conv);
        end
        // Start is sampled at the end of cycle k; done shows in cycle k+9E+1.
        checks++;
        if (lat !== 9 * int'(e.epoch)) begin
            failures++;
            $display("FAIL %s.latency got=%0d exp=%0d", name, lat, 9 * int'(e.epoch));
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s.busy_in_done got=%b exp=0", name, bus.busy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s.after_done got done=%b busy=%b exp 0/0", name, bus.done, bus.busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.w0, bus.w1, bus.w2, bus.epoch, bus.busy, bus.done, bus.converged} !== '0) begin
            failures++;
            $display("FAIL reset got w=%h/%h/%h ep=%0d busy=%b done=%b conv=%b exp all 0",
                     bus.w0, bus.w1, bus.w2, bus.epoch, bus.busy, bus.done, bus.converged);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_or_training();
        logic [3:0]  or_d = 4'b1110;
        logic [15:0] v_exp;
        drive_run("or", OR_IN1, OR_IN2, or_d, HF_ZERO, HF_ZERO, HF_ZERO, MODE_PROBE);
        or_exp = last_exp;
        checks++;
        if (bus.converged !== 1'b1 || bus.epoch > 4'd15) begin
            failures++;
            $display("FAIL or.converged got conv=%b ep=%0d exp conv=1 ep<=15", bus.converged, bus.epoch);
        end
        for (int i = 0; i < 4; i++) begin
            tx1 = OR_IN1[i];
            tx2 = OR_IN2[i];
            #1;
            v_exp = model_v(tx1, tx2, or_exp.w0, or_exp.w1, or_exp.w2);
            checks++;
            if (ty !== or_d[i] || tv !== v_exp) begin
                failures++;
                $display("FAIL or.classify%0d got y=%b v=%h exp y=%b v=%h", i, ty, tv, or_d[i], v_exp);
            end
        end
    endtask

    task automatic test_pretrained();
        drive_run("pretrained", OR_IN1, OR_IN2, 4'b1110, or_exp.w0, or_exp.w1, or_exp.w2, MODE_NORMAL);
        checks++;
        if (bus.epoch !== 4'd1 || {bus.w0, bus.w1, bus.w2} !== {or_exp.w0, or_exp.w1, or_exp.w2}) begin
            failures++;
            $display("FAIL pretrained.identity got ep=%0d w=%h/%h/%h exp ep=1 w=%h/%h/%h",
                     bus.epoch, bus.w0, bus.w1, bus.w2, or_exp.w0, or_exp.w1, or_exp.w2);
        end
    endtask

    task automatic test_xor();
        drive_run("xor", OR_IN1, OR_IN2, 4'b0110, HF_ZERO, HF_ZERO, HF_ZERO, MODE_NORMAL);
        checks++;
        if (bus.converged !== 1'b0 || bus.epoch !== 4'd15 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL xor.limit got conv=%b ep=%0d busy=%b exp conv=0 ep=15 busy=0",
                     bus.converged, bus.epoch, bus.busy);
        end
    endtask

    task automatic test_start_while_busy();
        drive_run("busy_start", OR_IN1, OR_IN2, 4'b1110, 16'h3C00, 16'hBC00, 16'h0000, MODE_DISTURB);
    endtask

    task automatic test_reset_mid_run();
        drive_run("abort", OR_IN1, OR_IN2, 4'b0110, HF_ZERO, HF_ZERO, HF_ZERO, MODE_ABORT);
        drive_run("after_abort", OR_IN1, OR_IN2, 4'b1000, 16'h3800, 16'h3400, 16'hB400, MODE_NORMAL);
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.in1     = '0;
        bus.in2     = '0;
        bus.d       = '0;
        bus.w0_init = '0;
        bus.w1_init = '0;
        bus.w2_init = '0;
        tx1         = '0;
        tx2         = '0;
        @(negedge clk);
        test_reset();
        test_or_training();
        test_pretrained();
        test_xor();
        test_start_while_busy();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=no finish exp=finish before 1ms");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Sequential training engine for the three-input half-precision perceptron. It iterates epochs over a four-sample training set and applies the perceptron rule on every misclassification. It stops when an epoch has zero errors or when the epoch limit is reached. Its registered weights w0/w1/w2 drive the weight inputs of the combinational perceptron evaluator directly downstream.

## Interface
Parameters:
- tam, 16, word width; IEEE 754 half precision, fixed at 16.
- MAX_EPOCH, 15, maximum number of epochs per run (1..15).
- ETA, 16'h3800, learning rate (+0.5).
- BIAS, 16'hBA66, constant bias input x0 (about -0.8).

Ports (clk and rst first):
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, begins a run; sampled only in IDLE.
- in1, input, [3:0][tam-1:0], x1 of samples 0..3.
- in2, input, [3:0][tam-1:0], x2 of samples 0..3.
- d, input, [3:0], desired class of samples 0..3.
- w0_init / w1_init / w2_init, input, tam each, starting weights, loaded on start.
- w0 / w1 / w2, output, tam each, current weights (registered).
- busy, output, 1, high from the cycle after start through the final CHECK.
- done, output, 1, one-cycle pulse at run end.
- converged, output, 1, 1 when the last run ended with a zero-error epoch; held until the next start.
- epoch, output, 4, number of epochs completed in the current or last run.

## Operation
- States: IDLE, EVAL, UPD, CHECK, DONE.
- **IDLE**
  - On start=1: latch in1, in2 and d into internal sample registers.
  - Load w* from w*_init; clear idx, err_cnt, epoch and converged.
  - Go to EVAL.
  - Inputs may change after the start cycle without effect.
- **EVAL**
  - Compute v = BIAS*w0 + in1[idx]*w1 + in2[idx]*w2 with the shared half-float multi16/sum16 cells (en tied 1).
  - Evaluation order: (m0+m1)+m2.
  - Register y = ~v[15]. A -0 result gives y=0. NaN follows its sign bit.
  - Go to UPD.
- **UPD**
  - If y == d[idx]: no change.
  - If y != d[idx]:
    - Compute p_k = ETA*x_k, with x0=BIAS, x1=in1[idx], x2=in2[idx].
    - If d=0 (y=1), invert the sign bit of p_k. If d=1, use it unchanged.
    - w_k <= w_k + p_k for all three weights in the same edge.
    - err_cnt++.
  - If idx==3, go to CHECK. Otherwise idx++ and go to EVAL.
- **CHECK**
  - epoch++.
  - If err_cnt==0: converged<=1, go to DONE.
  - Else if epoch+1 == MAX_EPOCH: go to DONE (converged stays 0).
  - Else clear idx and err_cnt, go to EVAL.
- **DONE**
  - done=1 for this one cycle; busy=0.
  - Next state is IDLE.
- Weights are held between runs. The downstream evaluator sees stable values whenever busy=0.
- start while busy (EVAL/UPD/CHECK/DONE) is ignored.
- Arithmetic:
  - All values are half precision. No rounding beyond what the fpu cells produce.
  - err_cnt is 3 bits (0..4) and does not saturate.

## Timing
- Reset values: state=IDLE, w0=w1=w2=16'h0000, busy=0, done=0, converged=0, epoch=0, idx=0, err_cnt=0.
- Reset mid-run aborts immediately to these values. No done pulse is produced.
- Each epoch takes 9 cycles: 4×(EVAL+UPD) + CHECK.
- With start sampled at edge k and E epochs run, done is high in cycle k+9E+1.
- Weight updates become visible on w* one cycle after the UPD edge.
- Combinational path per cycle is multi16 -> sum16 -> sum16 (EVAL) or multi16 -> sum16 (UPD). There is no multi-cycle path.

## Structure
- Shared package perceptron_pkg holds:
  - the state enum;
  - half-float constants (HF_ZERO 16'h0000, ETA and BIAS defaults, sign-bit index);
  - the EPOCH_W=4 typedef.
- Sub-module perceptron_eval: combinational dot product plus sign, three multi16 and two sum16.
  - Inputs: x0, x1, x2, w0, w1, w2. Outputs: v, y.
  - Instantiated once inside the trainer and reused as the downstream tester.
- The update path uses three multi16 and three sum16 inside the trainer.

## Test plan
- **OR training.** Samples (x1,x2) = (0,0), (0,1), (1,0), (1,1), i.e. in1 = {3C00, 3C00, 0000, 0000} and in2 = {3C00, 0000, 3C00, 0000} listed idx3..0, d=4'b1110, w*_init=0.
  - Required: converged=1, epoch ≤ 15, done at k+9E+1.
  - Final w* passed through perceptron_eval classify all 4 samples correctly.
- **Pre-trained weights.** Load the OR weights from the previous run as w*_init and start.
  - Required: E=1, done at k+10, converged=1, w* bit-identical to the init values.
- **XOR (non-separable).** d=4'b0110.
  - Required: converged=0, epoch=15, done at k+136, busy low afterwards.
- **Start while busy.** Pulse start at cycles k+3 and k+9 with different inputs.
  - Required: no restart; results identical to an undisturbed run.
- **Reset mid-run.** Assert rst at cycle k+20 of an XOR run.
  - Required: all outputs take their reset values within the reset cycle, with no done pulse.
  - A subsequent start runs normally.
- **Single update check.** w*_init=0, sample 0 = (0,0), d[0]=0.
  - First UPD must give w0 = 16'h3666 (+0.4) and w1 = w2 = 16'h0000.
